// File: rtl/strided_read_channel.sv
// Strided read DMA channel: issues base+k*stride reads, buffers data in a FWFT FIFO.
// Optional STRELA_READ_STALL_COUNT_EN adds a saturating stall_cycles_o counter.
module strided_read_channel #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        clear_i,
  input  logic [31:0] base_addr_i,
  input  logic [15:0] size_i,
  input  logic [15:0] stride_i,
  output logic [31:0] ar_addr_o,
  output logic        ar_valid_o,
  input  logic        ar_ready_i,
  input  logic [31:0] r_data_i,
  input  logic        r_valid_i,
  output logic        r_ready_o,
  output logic [31:0] data_o,
  output logic        data_valid_o,
  input  logic        data_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        stall_o
`ifdef STRELA_READ_STALL_COUNT_EN
  ,
  output logic [31:0] stall_cycles_o
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  state_e          state_q;
  logic [31:0]     addr_q;
  logic [15:0]     size_q;
  logic [15:0]     stride_q;
  logic [15:0]     issued_q;
  logic [15:0]     consumed_q;
  logic [15:0]     consumed_d;
  logic [CW-1:0]   outst_q;
  logic [CW-1:0]   outst_d;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   wptr_q;
  logic [PW-1:0]   rptr_q;
  logic [31:0]     mem_q [FIFO_DEPTH];

  logic run;
  logic flush;
  logic pending;
  logic credit_ok;
  logic ar_fire;
  logic r_fire;
  logic push;
  logic pop;
  logic start_ok;

  // Handshakes, credit check and output decode from registered state
  always_comb begin
    run          = state_q == RUN;
    flush        = state_q == FLUSH;
    pending      = issued_q < size_q;
    credit_ok    = ((CW+1)'(outst_q) + (CW+1)'(count_q))
                   < (CW+1)'(FIFO_DEPTH);
    ar_valid_o   = run && pending && credit_ok;
    stall_o      = run && pending && !credit_ok;
    r_ready_o    = run || flush;
    ar_addr_o    = addr_q;
    data_valid_o = count_q != '0;
    data_o       = mem_q[rptr_q];
    busy_o       = run || flush;
    done_o       = state_q == DONE;
    ar_fire      = ar_valid_o && ar_ready_i;
    r_fire       = r_ready_o && r_valid_i;
    push         = r_fire && run && !clear_i;
    pop          = data_valid_o && data_ready_i && !clear_i;
    outst_d      = outst_q + CW'(ar_fire) - CW'(r_fire);
    consumed_d   = consumed_q + 16'(pop);
    start_ok     = start_i && !clear_i &&
                   (state_q == IDLE || state_q == DONE);
  end

  // Control FSM, address generator and transfer counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      stride_q   <= '0;
      issued_q   <= '0;
      consumed_q <= '0;
      outst_q    <= '0;
    end else if (clear_i) begin
      issued_q   <= '0;
      consumed_q <= '0;
      outst_q    <= outst_d;
      state_q    <= (outst_d != '0) ? FLUSH : IDLE;
    end else begin
      outst_q <= outst_d;
      unique case (state_q)
        IDLE, DONE: begin
          if (start_ok) begin
            addr_q     <= base_addr_i;
            size_q     <= size_i;
            stride_q   <= stride_i;
            issued_q   <= '0;
            consumed_q <= '0;
            state_q    <= (size_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (ar_fire) begin
            issued_q <= issued_q + 16'd1;
            addr_q   <= addr_q + {16'h0, stride_q};
          end
          consumed_q <= consumed_d;
          if (consumed_d == size_q) state_q <= DONE;
        end
        FLUSH: begin
          if (outst_d == '0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // First-word-fall-through response buffer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= r_data_i;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

`ifdef STRELA_READ_STALL_COUNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of credit-stalled cycles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (clear_i || start_ok) begin
      stall_cnt_q <= '0;
    end else if (stall_o && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_strided_read_channel.sv
// Scoreboard bench for strided_read_channel: memory responder,
// consumer, address/data queues filled from base+k*stride.
module tb_strided_read_channel;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic        clear_i;
  logic [31:0] base_addr_i;
  logic [15:0] size_i;
  logic [15:0] stride_i;
  logic [31:0] ar_addr_o;
  logic        ar_valid_o;
  logic        ar_ready_i;
  logic [31:0] r_data_i;
  logic        r_valid_i;
  logic        r_ready_o;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic        data_ready_i;
  logic        busy_o;
  logic        done_o;
  logic        stall_o;
`ifdef STRELA_READ_STALL_COUNT_EN
  logic [31:0] stall_cycles_o;
`endif

  strided_read_channel #(.FIFO_DEPTH(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .clear_i      (clear_i),
    .base_addr_i  (base_addr_i),
    .size_i       (size_i),
    .stride_i     (stride_i),
    .ar_addr_o    (ar_addr_o),
    .ar_valid_o   (ar_valid_o),
    .ar_ready_i   (ar_ready_i),
    .r_data_i     (r_data_i),
    .r_valid_i    (r_valid_i),
    .r_ready_o    (r_ready_o),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .stall_o      (stall_o)
`ifdef STRELA_READ_STALL_COUNT_EN
    ,
    .stall_cycles_o (stall_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_d = -10;
  int ar_seen = 0;
  int resp_k = 0;
  int r_cnt = 0;

  int ar_mode = 1;
  bit ar_man = 1'b0;
  int d_mode = 1;
  bit r_hold = 1'b0;
  bit r_rand = 1'b0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] rq[$];

  function automatic logic [31:0] mdata(logic [31:0] a, int k);
    logic [31:0] kk;
    kk = k;
    return (a * 32'h9E3779B1) ^ {16'hC0DE, kk[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Memory responder and consumer, driven at the falling edge
  initial begin : driver
    bit ar_f;
    bit r_f;
    logic [31:0] ar_a;
    ar_f = 0;
    r_f = 0;
    ar_a = '0;
    ar_ready_i = 0;
    r_valid_i = 0;
    r_data_i = '0;
    data_ready_i = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_ni) begin
        rq.delete();
        ar_f = 0;
        r_f = 0;
        r_valid_i = 0;
      end else begin
        if (r_f) begin
          void'(rq.pop_front());
          r_cnt++;
        end
        if (ar_f) begin
          rq.push_back(mdata(ar_a, resp_k));
          resp_k++;
        end
        unique case (ar_mode)
          0: ar_ready_i = 1'($urandom_range(0, 1));
          1: ar_ready_i = 1'b1;
          default: ar_ready_i = ar_man;
        endcase
        unique case (d_mode)
          0: data_ready_i = 1'b0;
          1: data_ready_i = 1'b1;
          default: data_ready_i = 1'($urandom_range(0, 1));
        endcase
        if (rq.size() > 0 && !r_hold &&
            (!r_rand || $urandom_range(0, 1) == 1)) begin
          r_valid_i = 1'b1;
          r_data_i  = rq[0];
        end else begin
          r_valid_i = 1'b0;
        end
      end
      #1;
      ar_f = ar_valid_o && ar_ready_i;
      ar_a = ar_addr_o;
      r_f  = r_valid_i && r_ready_o;
    end
  end

  // Monitor: pops expected address/data on every handshake
  initial begin : monitor
    bit hold_chk;
    logic [31:0] hold_a;
    logic [31:0] e;
    hold_chk = 0;
    hold_a = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_ni) begin
        hold_chk = 0;
      end else begin
        if (hold_chk && ar_valid_o) chk("ar_hold", ar_addr_o, hold_a);
        hold_chk = ar_valid_o && !ar_ready_i;
        hold_a = ar_addr_o;
        if (ar_valid_o && ar_ready_i) begin
          ar_seen++;
          if (exp_addr.size() == 0) begin
            chk("ar_unexpected", ar_addr_o, 64'hFFFF_FFFF_FFFF);
          end else begin
            e = exp_addr.pop_front();
            chk("ar_addr", ar_addr_o, e);
          end
        end
        if (data_valid_o && data_ready_i) begin
          last_d = cyc;
          if (exp_data.size() == 0) begin
            chk("data_unexpected", data_o, 64'hFFFF_FFFF_FFFF);
          end else begin
            e = exp_data.pop_front();
            chk("data", data_o, e);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic start_xfer(input logic [31:0] b, input logic [15:0] n,
                            input logic [15:0] s);
    logic [31:0] a;
    step();
    base_addr_i = b;
    size_i = n;
    stride_i = s;
    start_i = 1'b1;
    ar_seen = 0;
    resp_k = 0;
    for (int k = 0; k < int'(n); k++) begin
      a = b + 32'(k) * {16'h0, s};
      exp_addr.push_back(a);
      exp_data.push_back(mdata(a, k));
    end
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done_o && n < budget) begin
      step();
      n++;
    end
    chk("done_reached", done_o, 1);
    chk("done_timing", cyc, last_d + 1);
    chk("queues_empty", exp_addr.size() + exp_data.size(), 0);
  endtask

  task automatic chk_idle_outs(input string nm);
    chk(nm, {ar_valid_o, r_ready_o, data_valid_o, busy_o, done_o, stall_o},
        0);
    chk({nm, "_addr"}, ar_addr_o, 0);
    chk({nm, "_data"}, data_o, 0);
`ifdef STRELA_READ_STALL_COUNT_EN
    chk({nm, "_stallcnt"}, stall_cycles_o, 0);
`endif
  endtask

  initial begin : stim
    int r0;
    int n;
`ifdef STRELA_READ_STALL_COUNT_EN
    logic [31:0] s0;
`endif
    rst_ni = 1'b0;
    start_i = 1'b0;
    clear_i = 1'b0;
    base_addr_i = '0;
    size_i = '0;
    stride_i = '0;
    #1;
    chk_idle_outs("reset");
    step();
    step();
    rst_ni = 1'b1;
    step();

    // Basic contiguous transfer, R one cycle after AR
    ar_mode = 1;
    d_mode = 1;
    start_xfer(32'h1000, 16'd4, 16'd4);
    chk("busy_run", busy_o, 1);
    wait_done(100);
    step();
    chk("done_held", done_o, 1);

    // Credit stall with the consumer blocked
    d_mode = 0;
    start_xfer(32'h4000, 16'd8, 16'd4);
    repeat (15) step();
    chk("stall_ar_count", ar_seen, 4);
    chk("stall_flag", stall_o, 1);
    chk("stall_no_arvalid", ar_valid_o, 0);
`ifdef STRELA_READ_STALL_COUNT_EN
    s0 = stall_cycles_o;
    step();
    chk("stall_cnt_inc", stall_cycles_o, s0 + 32'd1);
`endif
    d_mode = 1;
    wait_done(100);
    chk("stall_total_ar", ar_seen, 8);

    // Address wrap past 2^32
    start_xfer(32'hFFFF_FFF8, 16'd3, 16'd8);
    wait_done(100);

    // Zero-size start
    start_xfer(32'h5000, 16'd0, 16'd4);
    chk("size0_done", done_o, 1);
    chk("size0_noar", ar_valid_o, 0);
    step();
    chk("size0_ar_count", ar_seen, 0);

    // Zero stride repeats the base
    start_xfer(32'h6000, 16'd3, 16'd0);
    wait_done(100);

    // Random transfers with random back-pressure
    ar_mode = 0;
    d_mode = 2;
    r_rand = 1'b1;
    for (int t = 0; t < 6; t++) begin
      start_xfer($urandom, 16'($urandom_range(1, 24)),
                 16'($urandom_range(0, 65535)));
      wait_done(3000);
    end
    r_rand = 1'b0;

    // Clear with two reads outstanding
    ar_mode = 2;
    ar_man = 1'b0;
    r_hold = 1'b1;
    d_mode = 1;
    start_xfer(32'h2000, 16'd8, 16'd4);
    ar_man = 1'b1;
    step();
    step();
    ar_man = 1'b0;
    step();
    chk("clr_ar_count", ar_seen, 2);
    clear_i = 1'b1;
    start_i = 1'b1;
    size_i = 16'd2;
    exp_addr.delete();
    exp_data.delete();
    r0 = r_cnt;
    step();
    clear_i = 1'b0;
    start_i = 1'b0;
    chk("flush_busy", busy_o, 1);
    chk("flush_rready", r_ready_o, 1);
    chk("flush_noar", ar_valid_o, 0);
    chk("flush_nodone", done_o, 0);
`ifdef STRELA_READ_STALL_COUNT_EN
    chk("clr_stallcnt", stall_cycles_o, 0);
`endif
    r_hold = 1'b0;
    n = 0;
    while (busy_o && n < 20) begin
      step();
      chk("flush_nodata", data_valid_o, 0);
      n++;
    end
    chk("flush_to_idle", busy_o, 0);
    chk("flush_beats", r_cnt - r0, 2);
    chk("flush_rq_empty", rq.size(), 0);
    step();
    chk("clr_start_ignored", {busy_o, done_o}, 0);

    // Asynchronous reset mid-transfer
    ar_mode = 1;
    d_mode = 1;
    start_xfer(32'h7000, 16'd10, 16'd4);
    step();
    step();
    #1;
    rst_ni = 1'b0;
    #1;
    chk_idle_outs("midreset");
    exp_addr.delete();
    exp_data.delete();
    step();
    step();
    rst_ni = 1'b1;
    step();
    start_xfer(32'h8000, 16'd5, 16'd12);
    wait_done(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
